uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped 8N1 UART peripheral that sits on the CPU data-memory bus beside `cache`. It decodes its own address window and serializes bytes written by the CPU onto `O_tx`. It deserializes bytes arriving on `I_rx` into a readable register. It drives `O_stall` to hold the CPU while a transmit write cannot yet be accepted; the SoC ORs this into the CPU stall.

## Interface

- `CLK_HZ`, 48000000, core clock frequency in Hz.
- `BAUD`, 115200, line rate.
- `BASE_ADDR`, 32'h40000000, window base; the block decodes `I_addr[31:4] == BASE_ADDR[31:4]`.
- `I_clk` input 1: single clock, rising edge.
- `I_rst` input 1: reset, asynchronous, active-high.
- `I_addr` input 32: byte address from the CPU data port.
- `I_data` input 32: write data.
- `I_mask` input 4: byte-lane write mask.
- `I_we` input 1: write strobe.
- `O_data` output 32: read data, combinational from `I_addr`.
- `O_stall` output 1: hold request to the CPU.
- `O_tx` output 1: serial out, registered, idle high.
- `I_rx` input 1: serial in, asynchronous to `I_clk`.

## Operation

- `DIV = CLK_HZ / BAUD`, truncated; this is 416 at the defaults. The bit counter is `$clog2(DIV)` bits wide and counts 0..DIV-1.
- Register map, offset `I_addr[3:2]`:
  - 0 DATA: write pushes `I_data[7:0]` to TX; read returns `{24'b0, rx_byte}`.
  - 1 STATUS: read `{28'b0, frame_err, overrun, rx_valid, tx_busy}`. Write-1-to-clear applies to bits 1..3 (`I_data[3:1]`).
  - 2, 3: read 0; writes ignored.
- A write takes effect only when `sel & I_we & I_mask[0]`. Unselected addresses read 0.
- TX path:
  - One holding register plus a 10-bit shifter.
  - FSM `TX_IDLE`→`TX_SHIFT`. In `TX_IDLE` with holding full, load `{1,byte,0}` and enter `TX_SHIFT`. In `TX_SHIFT`, shift one bit LSB-first every DIV cycles. After the stop bit completes, return to `TX_IDLE`.
  - `tx_busy = holding_full | (state == TX_SHIFT)`.
- TX stall: `O_stall = sel & I_we & I_mask[0] & (offset == 0) & holding_full`. This is combinational. While stalled the write is not taken. It is taken in the first cycle holding is empty.
- RX path:
  - `I_rx` passes through a 2-flop synchronizer.
  - FSM `RX_IDLE`→`RX_START`→`RX_DATA`→`RX_STOP`.
  - `RX_IDLE`: a synchronized low sample moves to `RX_START` and clears the counter.
  - `RX_START`: at DIV/2 cycles, if the line is high it is a false start; return to `RX_IDLE` with no flag. Otherwise enter `RX_DATA`.
  - `RX_DATA`: sample at each subsequent DIV, 8 bits LSB-first.
  - `RX_STOP`: sample after one more DIV, then return to `RX_IDLE`.
- At stop sample:
  - If `rx_valid == 0`: load `rx_byte` and set `rx_valid`. If the stop bit sampled low, also set `frame_err`.
  - If `rx_valid == 1`: keep the old byte, discard the new one, and set `overrun`.
- Simultaneous events:
  - Clear of `rx_valid` in the same cycle as a new byte completing: the new byte wins. `rx_valid` stays 1, `rx_byte` updates, and `overrun` is not set.
  - Clear of `overrun` or `frame_err` coincident with a new set: the set wins.
- Reset (async, any time, including mid-frame) forces:
  - both FSMs to IDLE; holding empty; all flags 0; `rx_byte` 0; counters 0;
  - synchronizer flops 1; `O_tx = 1`.
  - `O_stall` is then 0 and a STATUS read returns 0.

## Timing

- Write accepted at edge N with holding empty and TX idle: the shifter loads at edge N+1, so `O_tx` falls after edge N+1.
- Each bit lasts exactly DIV cycles; a frame is 10·DIV cycles.
- Holding is free from edge N+1, so a second write is accepted without stall.
- A third write while the shifter is busy and holding is full stalls. It is accepted in the cycle after the shifter loads the second byte.
- Consecutive frames have no idle gap: the next start bit begins the cycle after the stop bit's last cycle.
- RX latency: `rx_valid` rises 2 (sync) + DIV/2 + 9·DIV cycles after the start-bit falling edge at `I_rx`, ±1 cycle.
- `O_data` and `O_stall` have zero latency. All flag updates are visible in the read the cycle after the edge that sets them.

## Test plan

- Reset: assert `I_rst` mid-TX-frame of 0x55 → `O_tx` = 1 immediately (async); STATUS = 0 and `O_stall` = 0 after release.
- Single TX 0x55 → `O_tx` low 416 cycles, then 1,0,1,0,1,0,1,0 at 416 cycles each, then stop high; `tx_busy` drops after 4160 cycles.
- Back-to-back writes 0x01, 0x02, 0x03 → the first two are accepted with no stall. The third shows `O_stall` = 1 until the 0x02 frame starts, ≈4160 cycles. Three contiguous frames appear on `O_tx`.
- RX 0xA3 at 115200 → `rx_valid` = 1 and DATA reads 0x000000A3. Writing STATUS 0x2 clears `rx_valid`.
- RX 0x11 then 0x22 without clearing → DATA = 0x11, `overrun` = 1. Framing: 0x5A with low stop bit → `frame_err` = 1, byte = 0x5A.
- Glitch: `I_rx` low for 100 cycles → no `rx_valid` and no flag; the RX FSM is back in IDLE before 416 cycles.

Source files
------------

// File: rtl/uart_mmio_if.sv
// CPU data-bus slice seen by the UART window: address, write data/mask/strobe,
// combinational read data and the transmit-side stall back to the CPU.
interface uart_mmio_if;
  logic [31:0] I_addr;
  logic [31:0] I_data;
  logic [3:0]  I_mask;
  logic        I_we;
  logic [31:0] O_data;
  logic        O_stall;

  modport master (
    output I_addr, I_data, I_mask, I_we,
    input  O_data, O_stall
  );

  modport slave (
    input  I_addr, I_data, I_mask, I_we,
    output O_data, O_stall
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: DATA/STATUS registers in a 16-byte window, one TX holding
// register in front of a 10-bit shifter, and a mid-bit sampling receiver.
module uart_mmio #(
  parameter int unsigned CLK_HZ    = 48000000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  uart_mmio_if.slave  bus,
  input  logic        I_rx,
  output logic        O_tx
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] DivLast  = CW'(DIV - 1);
  localparam logic [CW-1:0] HalfLast = CW'(DIV / 2 - 1);

  typedef enum logic {TxIdle, TxShift} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [8:0]    tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_q, tx_d;
  logic          tx_load;

  rx_state_e     rx_state_q, rx_state_d;
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          stop_evt;

  logic       sel, wr_en, data_wr, stat_wr, tx_busy;
  logic [1:0] offset;
  logic       unused_bits;

  assign sel     = bus.I_addr[31:4] == BASE_ADDR[31:4];
  assign offset  = bus.I_addr[3:2];
  assign wr_en   = sel & bus.I_we & bus.I_mask[0];
  assign data_wr = wr_en & (offset == 2'd0) & ~hold_full_q;
  assign stat_wr = wr_en & (offset == 2'd1);
  assign tx_busy = hold_full_q | (tx_state_q == TxShift);
  assign O_tx    = tx_q;

  assign bus.O_stall = wr_en & (offset == 2'd0) & hold_full_q;
  assign unused_bits = ^{bus.I_addr[1:0], bus.I_data[31:8], bus.I_mask[3:1]};

  always_comb begin
    bus.O_data = '0;
    if (sel) begin
      unique case (offset)
        2'd0:    bus.O_data = {24'b0, rx_byte_q};
        2'd1:    bus.O_data = {28'b0, frame_err_q, overrun_q, rx_valid_q, tx_busy};
        default: bus.O_data = '0;
      endcase
    end
  end

  // Loading straight out of the stop bit's final cycle keeps back-to-back frames gapless.
  always_comb begin
    tx_state_d  = tx_state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_d        = tx_q;
    tx_load     = 1'b0;
    if (data_wr) begin
      hold_d      = bus.I_data[7:0];
      hold_full_d = 1'b1;
    end
    unique case (tx_state_q)
      TxIdle: tx_load = hold_full_q;
      TxShift: begin
        if (tx_cnt_q == DivLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TxIdle;
            tx_load    = hold_full_q;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
    endcase
    if (tx_load) begin
      tx_state_d  = TxShift;
      tx_shift_d  = {1'b1, hold_q};
      tx_d        = 1'b0;
      tx_cnt_d    = '0;
      tx_bit_d    = '0;
      hold_full_d = 1'b0;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    stop_evt    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          stop_evt   = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase
    if (stat_wr && bus.I_data[1]) rx_valid_d  = 1'b0;
    if (stat_wr && bus.I_data[2]) overrun_d   = 1'b0;
    if (stat_wr && bus.I_data[3]) frame_err_d = 1'b0;
    // A clear of rx_valid landing with a new byte counts as empty: the new byte wins.
    if (stop_evt) begin
      if (!rx_valid_q || (stat_wr && bus.I_data[1])) begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        if (!rx_sync_q) frame_err_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      tx_state_q  <= TxIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= I_rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Randomised bench for uart_mmio: queued TX frames and register reads are checked by
// independent monitors against a behavioural model of the UART rules.
module tb_uart_mmio;
  localparam int unsigned CLK_HZ = 2_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned HALF   = DIV / 2;
  localparam longint      FRAME  = 10 * DIV;
  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  uart_mmio_if bus();

  uart_mmio #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .BASE_ADDR(BASE)
  ) dut (
    .I_clk(clk),
    .I_rst(rst),
    .bus  (bus),
    .I_rx (rx),
    .O_tx (tx)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  // Model state: TX frames promised to the line, and the receiver's register view.
  typedef struct {logic [7:0] b; longint l;} tx_item_t;
  tx_item_t   tx_q[$];
  longint     last_l = -100000;
  bit         m_valid, m_ovr, m_fe;
  logic [7:0] m_byte;

  logic [31:0] rd_exp[$];
  string       rd_name[$];
  logic        rd_pend = 1'b0;
  longint      rx_s_edge = -1;

  function automatic logic [31:0] status_exp();
    return {28'b0, m_fe, m_ovr, m_valid, (cyc < last_l + FRAME)};
  endfunction

  task automatic model_reset();
    tx_q.delete();
    last_l  = -100000;
    m_valid = 0;
    m_ovr   = 0;
    m_fe    = 0;
    m_byte  = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk);
    #1;
    bus.I_addr = a;
    bus.I_we   = 1'b0;
    rd_exp.push_back((a == A_STAT) ? status_exp() : exp);
    rd_name.push_back(nm);
    rd_pend = 1'b1;
    @(negedge clk);
    #1;
    rd_pend = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    longint   k, exp_n, n, l;
    bit       eff, is_tx, timed_out;
    int       waited;
    tx_item_t it;
    @(posedge clk);
    #1;
    k     = cyc;
    eff   = (a[31:4] == BASE[31:4]) && m[0];
    is_tx = eff && (a[3:2] == 2'd0);
    exp_n = is_tx ? lmax(k + 1, last_l + 1) : k + 1;
    bus.I_addr = a;
    bus.I_data = d;
    bus.I_mask = m;
    bus.I_we   = 1'b1;
    waited     = 0;
    timed_out  = 0;
    forever begin
      @(negedge clk);
      if (!bus.O_stall) break;
      waited++;
      if (waited > 3 * FRAME) begin
        timed_out = 1;
        break;
      end
    end
    n = cyc + 1;
    check("wr_stall_bounded", timed_out, 0);
    if (!timed_out) begin
      @(posedge clk);
      #1;
      check("wr_accept_edge", n, exp_n);
    end
    bus.I_we = 1'b0;
    if (is_tx) begin
      l = lmax(exp_n + 1, last_l + FRAME);
      it.b = d[7:0];
      it.l = l;
      tx_q.push_back(it);
      last_l = l;
    end
    if (eff && a[3:2] == 2'd1) begin
      if (d[1]) m_valid = 0;
      if (d[2]) m_ovr   = 0;
      if (d[3]) m_fe    = 0;
    end
  endtask

  task automatic wait_tx_idle();
    while (cyc < last_l + FRAME + 4) @(posedge clk);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk);
    #2;
    rx_s_edge = cyc;
    rx = fr[0];
    for (int i = 1; i < 10; i++) begin
      repeat (DIV) @(posedge clk);
      #2 rx = fr[i];
    end
    repeat (DIV) @(posedge clk);
    #2 rx = 1'b1;
    repeat (DIV) @(posedge clk);
    if (!m_valid) begin
      m_byte  = b;
      m_valid = 1;
      if (!stop) m_fe = 1;
    end else begin
      m_ovr = 1;
    end
  endtask

  // Read monitor: compares each queued read against O_data away from the clock edge.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp.size() == 0) begin
        check("rd_queue_underflow", rd_exp.size(), 1);
      end else begin
        check(rd_name.pop_front(), bus.O_data, rd_exp.pop_front());
      end
    end
  end

  // TX monitor: a low line starts a frame; every cycle of it is compared to the model.
  initial begin
    longint     l0;
    int         errs;
    bit         aborted, have;
    logic [9:0] fr;
    tx_item_t   it;
    forever begin
      @(negedge clk);
      if (!rst && tx == 1'b0) begin
        l0      = cyc;
        errs    = 0;
        aborted = 0;
        fr      = '1;
        have    = (tx_q.size() != 0);
        if (!have) begin
          check("tx_unexpected_frame", tx_q.size(), 1);
        end else begin
          it = tx_q.pop_front();
          fr = {1'b1, it.b, 1'b0};
          check("tx_start_edge", l0, it.l);
        end
        for (int i = 0; i < int'(FRAME); i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          if (tx !== fr[i / DIV]) errs++;
        end
        if (have && !aborted) check("tx_frame_bits", errs, 0);
      end
    end
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] d;
    logic [3:0]  m;
    bus.I_addr = '0;
    bus.I_data = '0;
    bus.I_mask = '0;
    bus.I_we   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_tx_idle", tx, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    rd(A_STAT, 0, "reset_status");
    rd(A_DATA, 0, "reset_data");

    wr(A_DATA, 32'h55, 4'h1);
    rd(A_STAT, 0, "tx_busy_during_frame");
    wait_tx_idle();
    rd(A_STAT, 0, "tx_busy_after_frame");

    wr(A_DATA, 32'h01, 4'h1);
    wr(A_DATA, 32'h02, 4'h1);
    wr(A_DATA, 32'h03, 4'h1);
    rd(A_STAT, 0, "tx_busy_b2b");
    wait_tx_idle();

    // Writes that must not reach the transmitter.
    wr(A_DATA, 32'h77, 4'he);
    wr(BASE + 32'h10, 32'h66, 4'h1);
    wr(BASE + 32'h8, 32'h44, 4'h1);
    repeat (FRAME) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      wr(A_DATA, $urandom, 4'h1);
      if ($urandom_range(0, 1) == 1) rd(A_STAT, 0, "tx_busy_random");
      repeat ($urandom_range(0, 3 * FRAME / 2)) @(posedge clk);
      rd(A_STAT, 0, "tx_busy_random_gap");
    end
    wait_tx_idle();

    // Asynchronous reset in the middle of a frame with the holding register full.
    wr(A_DATA, 32'h55, 4'h1);
    wr(A_DATA, 32'hAA, 4'h1);
    repeat (2 * DIV + HALF) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("rst_async_tx_high", tx, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd(A_STAT, 0, "post_reset_status");
    wr(A_DATA, 32'h3C, 4'h1);
    wait_tx_idle();

    // RX 0xA3, with the rx_valid rise checked against its latency window.
    bus.I_addr = A_STAT;
    rx_s_edge  = -1;
    fork
      rx_send(8'hA3, 1'b1);
      begin
        wait (rx_s_edge >= 0);
        do @(negedge clk); while (cyc < rx_s_edge + HALF + 9 * DIV + 1);
        check("rx_valid_not_early", bus.O_data[1], 0);
        do @(negedge clk); while (cyc < rx_s_edge + HALF + 9 * DIV + 4);
        check("rx_valid_in_time", bus.O_data[1], 1);
      end
    join
    rd(A_DATA, 32'hA3, "rx_data_a3");
    rd(A_STAT, 0, "rx_status_a3");
    wr(A_STAT, 32'h2, 4'h1);
    rd(A_STAT, 0, "rx_valid_cleared");

    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    rd(A_DATA, 32'h11, "rx_overrun_keeps_old");
    rd(A_STAT, 0, "rx_overrun_status");
    wr(A_STAT, 32'hE, 4'h1);

    rx_send(8'h5A, 1'b0);
    rd(A_DATA, 32'h5A, "rx_frame_err_data");
    rd(A_STAT, 0, "rx_frame_err_status");
    wr(A_STAT, 32'hE, 4'h1);

    @(posedge clk);
    #2 rx = 1'b0;
    repeat (4) @(posedge clk);
    #2 rx = 1'b1;
    repeat (DIV) @(posedge clk);
    rd(A_STAT, 0, "rx_glitch_no_flag");
    rx_send(8'h96, 1'b1);
    rd(A_DATA, 32'h96, "rx_after_glitch");
    rd(BASE + 32'h10, 0, "unselected_read");
    rd(BASE + 32'h8, 0, "reserved_read_2");
    rd(BASE + 32'hC, 0, "reserved_read_3");
    rd(32'hC000_0000, 0, "far_unselected_read");

    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom);
      rx_send(b, ($urandom_range(0, 4) != 0));
      rd(A_DATA, {24'b0, m_byte}, "rx_random_data");
      rd(A_STAT, 0, "rx_random_status");
      if ($urandom_range(0, 2) != 0) begin
        d = {28'b0, 4'($urandom)};
        m = 4'($urandom) | 4'($urandom_range(0, 3) != 0);
        wr(A_STAT, d, m);
        rd(A_STAT, 0, "rx_random_w1c");
      end
    end

    wait_tx_idle();
    repeat (4) @(posedge clk);
    check("tx_queue_drained", tx_q.size(), 0);
    check("rd_queue_drained", rd_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
